// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the button user-interface blocks: the decoder
// state encoding and default cycle counts for the robot system clock.
package key_event_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESSED  = 2'd1,
        LONG     = 2'd2,
        DBL_WAIT = 2'd3
    } state_t;

    // Default durations for the robot clock, shared with other UI blocks
    localparam int DEF_CNT_W         = 26;
    localparam int DEF_LONG_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;
    localparam int DEF_DBL_CYCLES    = 25_000_000;

endpackage

// File: rtl/key_event_decoder.sv
// Turns the debounced button level into single-cycle UI events: press,
// release (with long qualifier), long-press, auto-repeat, single-click and
// double-click. One shared counter times hold, repeat and the click window.
module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int DBL_CYCLES    = DEF_DBL_CYCLES,
    parameter int REPEAT_EN     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic release_long,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic click_pulse,
    output logic dbl_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DBL_LAST    = CNT_W'(DBL_CYCLES - 1);
    localparam logic             RPT_ON      = (REPEAT_EN != 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              second_q, second_d;
    logic              armed_q, armed_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              rel_long_q, rel_long_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              click_q, click_d;
    logic              dbl_q, dbl_d;
    logic              held_q, held_d;

    // Next-state, counter and event decode; events are registered below
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        second_d   = second_q;
        // Arming uses the current (pre-update) armed_q, so the sample that
        // arms cannot itself be accepted as a press.
        armed_d    = armed_q | ~key_in;
        press_d    = 1'b0;
        release_d  = 1'b0;
        rel_long_d = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        click_d    = 1'b0;
        dbl_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (armed_q && key_in) begin
                    state_d  = PRESSED;
                    cnt_d    = '0;
                    second_d = 1'b0;
                    press_d  = 1'b1;
                end
            end
            PRESSED: begin
                // Release wins over long expiry on the same sample
                if (!key_in) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = second_q ? IDLE : DBL_WAIT;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (!key_in) begin
                    state_d    = IDLE;
                    release_d  = 1'b1;
                    rel_long_d = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = RPT_ON;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DBL_WAIT: begin
                // A press on the expiry sample still counts as a double-click
                if (key_in) begin
                    state_d  = PRESSED;
                    cnt_d    = '0;
                    second_d = 1'b1;
                    press_d  = 1'b1;
                    dbl_d    = 1'b1;
                end else if (cnt_q == DBL_LAST) begin
                    state_d = IDLE;
                    click_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        held_d = (state_d == PRESSED) || (state_d == LONG);
    end

    // State, counter, arming and registered outputs; reset aborts silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            second_q   <= 1'b0;
            armed_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            rel_long_q <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            click_q    <= 1'b0;
            dbl_q      <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            second_q   <= second_d;
            armed_q    <= armed_d;
            press_q    <= press_d;
            release_q  <= release_d;
            rel_long_q <= rel_long_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
            click_q    <= click_d;
            dbl_q      <= dbl_d;
            held_q     <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign release_long  = rel_long_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign click_pulse   = click_q;
    assign dbl_pulse     = dbl_q;
    assign held          = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed scenarios plus random key traffic,
// checked cycle by cycle against a timing-based reference model through a
// queue-based scoreboard. A second instance with repeat disabled runs in
// parallel on the same stimulus.
module tb_key_event_decoder;

    localparam int LONG_C = 8;
    localparam int REP_C  = 4;
    localparam int DBL_C  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_in = 1'b0;

    logic press_pulse, release_pulse, release_long, long_pulse;
    logic repeat_pulse, click_pulse, dbl_pulse, held;
    logic press_pulse2, release_pulse2, release_long2, long_pulse2;
    logic repeat_pulse2, click_pulse2, dbl_pulse2, held2;

    key_event_decoder #(
        .CNT_W(8), .LONG_CYCLES(LONG_C), .REPEAT_CYCLES(REP_C),
        .DBL_CYCLES(DBL_C), .REPEAT_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .release_long(release_long), .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse), .click_pulse(click_pulse),
        .dbl_pulse(dbl_pulse), .held(held)
    );

    key_event_decoder #(
        .CNT_W(8), .LONG_CYCLES(LONG_C), .REPEAT_CYCLES(REP_C),
        .DBL_CYCLES(DBL_C), .REPEAT_EN(0)
    ) dut_norpt (
        .clk(clk), .rst(rst), .key_in(key_in),
        .press_pulse(press_pulse2), .release_pulse(release_pulse2),
        .release_long(release_long2), .long_pulse(long_pulse2),
        .repeat_pulse(repeat_pulse2), .click_pulse(click_pulse2),
        .dbl_pulse(dbl_pulse2), .held(held2)
    );

    always #5 clk = ~clk;

    // Expected vector: {press, release, release_long, long, repeat, click, dbl, held}
    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: tracks time since press / since short release
    localparam int M_IDLE = 0, M_DOWN = 1, M_WAIT = 2;
    int m_mode   = M_IDLE;
    int m_h      = 0;   // samples since the press sample
    int m_w      = 0;   // samples since the short-release sample
    bit m_second = 1'b0;
    bit m_armed  = 1'b0;

    task automatic model_step(input bit k, input bit r, output logic [7:0] e);
        bit p, rl, rlong, lg, rp, ck, db;
        p = 0; rl = 0; rlong = 0; lg = 0; rp = 0; ck = 0; db = 0;
        if (r) begin
            m_mode = M_IDLE; m_h = 0; m_w = 0; m_second = 0; m_armed = 0;
            e = 8'h00;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (m_armed && k) begin
                        m_mode = M_DOWN; m_h = 0; m_second = 0; p = 1;
                    end
                end
                M_DOWN: begin
                    m_h++;
                    if (!k) begin
                        rl = 1;
                        rlong = (m_h > LONG_C);
                        if (rlong || m_second) m_mode = M_IDLE;
                        else begin m_mode = M_WAIT; m_w = 0; end
                    end else if (m_h == LONG_C) begin
                        lg = 1;
                    end else if (m_h > LONG_C && ((m_h - LONG_C) % REP_C) == 0) begin
                        rp = 1;
                    end
                end
                default: begin
                    m_w++;
                    if (k) begin
                        m_mode = M_DOWN; m_h = 0; m_second = 1; p = 1; db = 1;
                    end else if (m_w == DBL_C) begin
                        ck = 1; m_mode = M_IDLE;
                    end
                end
            endcase
            if (!k) m_armed = 1;
            e = {p, rl, rlong, lg, rp, ck, db, (m_mode == M_DOWN)};
        end
    endtask

    task automatic drive(input bit k, input bit r);
        logic [7:0] e;
        @(negedge clk);
        key_in = k;
        rst = r;
        model_step(k, r, e);
        exp_q.push_back(e);
    endtask

    task automatic run(input bit k, input int n);
        for (int i = 0; i < n; i++) drive(k, 1'b0);
    endtask

    task automatic run_rst(input bit k, input int n);
        for (int i = 0; i < n; i++) drive(k, 1'b1);
    endtask

    // Monitor: after each edge, compare both instances against the next expectation
    initial begin
        logic [7:0] got, got2, e, e2;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                e2 = e & 8'b1111_0111;
                got  = {press_pulse, release_pulse, release_long, long_pulse,
                        repeat_pulse, click_pulse, dbl_pulse, held};
                got2 = {press_pulse2, release_pulse2, release_long2, long_pulse2,
                        repeat_pulse2, click_pulse2, dbl_pulse2, held2};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs cycle=%0d got=%b exp=%b (press,rel,rlong,long,rpt,click,dbl,held)",
                             cyc, got, e);
                end
                checks++;
                if (got2 !== e2) begin
                    errors++;
                    $display("FAIL norepeat_outputs cycle=%0d got=%b exp=%b", cyc, got2, e2);
                end
            end
        end
    end

    initial begin
        int len;
        bit k;
        // Reset and idle
        run_rst(1'b0, 3);
        run(1'b0, 3);
        // Short click
        run(1'b1, 3); run(1'b0, 10);
        // Long press with repeats
        run(1'b1, 20); run(1'b0, 8);
        // Double-click
        run(1'b1, 3); run(1'b0, 2); run(1'b1, 3); run(1'b0, 10);
        // Window boundaries: 5, 6 and 7 low samples before the next press
        run(1'b1, 3); run(1'b0, 5); run(1'b1, 3); run(1'b0, 10);
        run(1'b1, 3); run(1'b0, 6); run(1'b1, 3); run(1'b0, 10);
        run(1'b1, 3); run(1'b0, 7); run(1'b1, 3); run(1'b0, 10);
        // Priority: release on the long-expiry sample is a short release
        run(1'b1, LONG_C); run(1'b0, 10);
        // Release one sample later is long
        run(1'b1, LONG_C + 1); run(1'b0, 4);
        // Second press goes long
        run(1'b1, 3); run(1'b0, 2); run(1'b1, 15); run(1'b0, 10);
        // Held through reset, released, pressed again
        run_rst(1'b1, 3); run(1'b1, 5); run(1'b0, 3); run(1'b1, 3); run(1'b0, 10);
        // Reset during LONG, key still held afterwards
        run(1'b1, 12); run_rst(1'b1, 2); run(1'b1, 4); run(1'b0, 3);
        // Random traffic with occasional resets
        k = 1'b0;
        for (int i = 0; i < 400; i++) begin
            k = ~k;
            len = (($urandom % 4) == 0) ? int'($urandom_range(8, 20))
                                         : int'($urandom_range(1, 8));
            if (($urandom % 40) == 0) run_rst(k, int'($urandom_range(1, 3)));
            run(k, len);
        end
        run(1'b0, 12);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
